// File: rtl/stack_engine.sv
// LIFO on a synchronous-read RAM: push, pop, replace (push+pop), peek at depth; sticky error flags.
// Pop and peek results appear one cycle after the request; a pop or replace wins the read port over a peek.
module stack_engine #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  input  logic                  peek_en,
  input  logic [ADDR_WIDTH-1:0] peek_offset,
  output logic [DATA_WIDTH-1:0] peek_data,
  output logic                  peek_valid,
  output logic                  peek_hit,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] pop_hold_q, peek_hold_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, full_q;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  pop_valid_q, peek_valid_q, peek_hit_q;

  logic                  pop_acc, push_acc, replace, peek_go, peek_in, rd_en, wr_en;
  logic [ADDR_WIDTH:0]   top_ext, peek_ext;
  logic [ADDR_WIDTH-1:0] waddr, raddr;

  always_comb begin
    pop_acc  = pop && !empty_q;
    // A full stack still takes a push when it is paired with an accepted pop (replace).
    push_acc = push && (!full_q || pop_acc);
    replace  = push_acc && pop_acc;
    peek_go  = peek_en && !pop_acc;
    top_ext  = count_q - ONE;
    peek_ext = top_ext - {1'b0, peek_offset};
    peek_in  = {1'b0, peek_offset} < count_q;
    waddr    = replace ? top_ext[ADDR_WIDTH-1:0] : count_q[ADDR_WIDTH-1:0];
    raddr    = pop_acc ? top_ext[ADDR_WIDTH-1:0] : peek_ext[ADDR_WIDTH-1:0];
    wr_en    = push_acc && !reset;
    rd_en    = pop_acc || (peek_go && peek_in);

    count_d = count_q;
    if (push_acc && !pop_acc)      count_d = count_q + ONE;
    else if (pop_acc && !push_acc) count_d = count_q - ONE;

    overflow_d  = (push && !push_acc) ? 1'b1 : (clear_err ? 1'b0 : overflow_q);
    underflow_d = (pop && !pop_acc)   ? 1'b1 : (clear_err ? 1'b0 : underflow_q);
  end

  // Read and write in one edge give read-before-write on an address collision.
  always_ff @(posedge clock) begin
    if (wr_en) mem[waddr] <= push_data;
    if (rd_en) rd_q <= mem[raddr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      pop_valid_q  <= 1'b0;
      peek_valid_q <= 1'b0;
      peek_hit_q   <= 1'b0;
      pop_hold_q   <= '0;
      peek_hold_q  <= '0;
    end else begin
      count_q      <= count_d;
      empty_q      <= (count_d == '0);
      full_q       <= (count_d == FULL_CNT);
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      pop_valid_q  <= pop_acc;
      peek_valid_q <= peek_go;
      peek_hit_q   <= peek_go && peek_in;
      if (pop_valid_q)  pop_hold_q  <= rd_q;
      if (peek_valid_q) peek_hold_q <= peek_hit_q ? rd_q : '0;
    end
  end

  assign pop_data   = pop_valid_q ? rd_q : pop_hold_q;
  assign peek_data  = peek_valid_q ? (peek_hit_q ? rd_q : '0) : peek_hold_q;
  assign pop_valid  = pop_valid_q;
  assign peek_valid = peek_valid_q;
  assign peek_hit   = peek_hit_q;
  assign count      = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised hardware LIFO built on an inferred synchronous-read RAM, with internal stack pointer and occupancy tracking.
- Accepts push, pop, simultaneous push+pop (replace top), and non-destructive peek at any depth.
- Provides full/empty status and sticky overflow/underflow error flags.
- Serves as the stack store for the datapath's expression and return-address logic, replacing bare RAM plus external pointer logic.

Parameters:
- DATA_WIDTH, 12, width of each stack entry.
- ADDR_WIDTH, 8, address width; DEPTH = 1<<ADDR_WIDTH entries.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- push  in  1  push request.
- push_data  in  DATA_WIDTH  data written on an accepted push.
- pop  in  1  pop request.
- pop_data  out  DATA_WIDTH  popped value, registered.
- pop_valid  out  1  one-cycle pulse: pop_data holds a value from an accepted pop.
- peek_en  in  1  peek request.
- peek_offset  in  ADDR_WIDTH  depth below top (0 = top).
- peek_data  out  DATA_WIDTH  peeked value, registered.
- peek_valid  out  1  one-cycle pulse: a peek was serviced.
- peek_hit  out  1  with peek_valid: 1 = offset in range, 0 = out of range (peek_data forced 0).
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: push rejected while full.
- underflow  out  1  sticky: pop rejected while empty.
- clear_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (synchronous, active-high, dominates all inputs):
  - count=0, empty=1, full=0.
  - overflow=0, underflow=0.
  - pop_data=0, pop_valid=0, peek_data=0, peek_valid=0, peek_hit=0.
  - RAM contents are not cleared.
- Storage:
  - Entries live at addresses 0..count-1; top of stack = count-1.
  - One write port, one read port.
  - Read-before-write: a read and a write to the same address in the same cycle return the old value.
- Push only, count<DEPTH:
  - mem[count] <= push_data; count+1.
- Push only, full:
  - Write suppressed, count unchanged, overflow <= 1.
- Pop only, count>0:
  - Reads mem[count-1]; count-1.
  - Next cycle: pop_data = value, pop_valid = 1.
- Pop only, empty:
  - No read, count unchanged, underflow <= 1, pop_valid = 0 next cycle.
- Push+pop, count>0 (replace), including when full:
  - pop_data <= old mem[count-1]; mem[count-1] <= push_data.
  - count unchanged, pop_valid pulses.
  - No overflow.
- Push+pop, empty:
  - Pop rejected (underflow <= 1, no pop_valid).
  - Push accepted; count becomes 1.
- Peek:
  - Latency 1 cycle; peek_valid pulses the cycle after peek_en.
  - offset < count: reads mem[count-1-offset] using pre-update count; peek_hit=1.
  - offset >= count: peek_data=0, peek_hit=0; no error flag set.
- Peek conflicts with pop on the single read port:
  - Any accepted pop or replace drops the peek; peek_valid stays 0.
  - A peek alongside a push-only proceeds, reading pre-push contents.
- pop_data and peek_data hold their last value when their valid is low (except the out-of-range peek, which forces 0).
- empty and full are registered and consistent with count in the same cycle.
- Error flags:
  - Stay set until clear_err or reset.
  - If clear_err coincides with a new error event, the flag is set (event wins).
- count arithmetic is ADDR_WIDTH+1 bits and never wraps; pointer saturation is enforced by the accept rules above.

Test Plan:
(All scenarios use DATA_WIDTH=12, ADDR_WIDTH=3, DEPTH=8.)
1. Reset, then push 0x101..0x108 on consecutive cycles -> count steps 1..8, full=1 after the 8th push. A 9th push 0x1FF -> overflow=1, count=8. Pop -> pop_data=0x108 with pop_valid one cycle later.
2. Pop from empty after reset -> underflow=1, pop_valid stays 0, count=0. clear_err -> underflow=0. clear_err with a simultaneous empty pop -> underflow remains 1.
3. Push 0x0AA, 0x0BB, then push 0x0CC with pop in the same cycle -> pop_data=0x0BB, count stays 2. Next pop -> 0x0CC, then pop -> 0x0AA, empty=1.
4. Fill to full (8 entries), push 0x777 with pop -> no overflow, pop_data = old top, new top = 0x777, count=8.
5. Stack holds 0x011, 0x022, 0x033 (top 0x033): peek offsets 0, 2, 3 -> peek_data 0x033/hit=1, 0x011/hit=1, 0x000/hit=0. count unchanged throughout.
6. peek_en with pop in the same cycle -> peek_valid=0, pop serviced. Assert reset mid-sequence with count=5 and push asserted -> next cycle count=0, empty=1, all flags and valids 0.
